// File: rtl/udp_audio_rx.sv
// GMII receive-side Ethernet II / IPv4 / UDP parser that unpacks the UDP payload into 16-bit
// stereo PCM pairs. Define UDP_AUDIO_RX_STAT_EN to add good/dropped frame counters.
module udp_audio_rx #(
    parameter logic [47:0] LOCAL_MAC   = 48'h000A3501FEC0,
    parameter logic [15:0] LOCAL_PORT  = 16'd8080,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic [15:0] ldata_out,
    output logic [15:0] rdata_out,
    output logic        sample_valid,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic        pkt_drop
`ifdef UDP_AUDIO_RX_STAT_EN
    ,
    output logic [15:0] good_pkt_cnt,
    output logic [15:0] drop_pkt_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StEthHdr,
        StIpHdr,
        StUdpHdr,
        StPayload,
        StWaitEnd
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] pay_len_q;
    logic [15:0] ulen_q;
    logic [7:0]  hi_byte_q;
    logic [7:0]  b0_q, b1_q, b2_q;
    logic        mac_match_q;
    logic        bcast_q;
    logic        hdr_ok_q;
    logic        armed_q;

    logic [7:0]  mac_byte;
    logic [15:0] pay_calc;
    logic        len_ok;

    always_comb begin
        mac_byte = LOCAL_MAC[47:40];
        case (cnt_q[2:0])
            3'd1:    mac_byte = LOCAL_MAC[39:32];
            3'd2:    mac_byte = LOCAL_MAC[31:24];
            3'd3:    mac_byte = LOCAL_MAC[23:16];
            3'd4:    mac_byte = LOCAL_MAC[15:8];
            3'd5:    mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = LOCAL_MAC[47:40];
        endcase
        pay_calc = ulen_q - 16'd8;
        len_ok   = (ulen_q >= 16'd8) && (pay_calc <= MAX_PAYLOAD);
    end

    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            pay_len_q    <= 16'd0;
            ulen_q       <= 16'd0;
            hi_byte_q    <= 8'd0;
            b0_q         <= 8'd0;
            b1_q         <= 8'd0;
            b2_q         <= 8'd0;
            mac_match_q  <= 1'b0;
            bcast_q      <= 1'b0;
            hdr_ok_q     <= 1'b0;
            armed_q      <= 1'b0;
            ldata_out    <= 16'd0;
            rdata_out    <= 16'd0;
            sample_valid <= 1'b0;
            pkt_start    <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_drop     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            pkt_start    <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_drop     <= 1'b0;
            // A frame already in flight at reset release is skipped until dv goes low.
            if (!gmii_rx_dv) armed_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (gmii_rx_dv) begin
                        state_q <= (armed_q && gmii_rxd == 8'h55) ? StPreamble : StWaitEnd;
                    end
                end
                StWaitEnd: begin
                    if (!gmii_rx_dv) state_q <= StIdle;
                end
                default: begin
                    if (!gmii_rx_dv) begin
                        state_q  <= StIdle;
                        pkt_drop <= (state_q != StPreamble);
                    end else if (gmii_rx_er) begin
                        state_q  <= StWaitEnd;
                        pkt_drop <= 1'b1;
                    end else begin
                        case (state_q)
                            StPreamble: begin
                                if (gmii_rxd == 8'hD5) begin
                                    state_q <= StEthHdr;
                                    cnt_q   <= 16'd0;
                                end else if (gmii_rxd != 8'h55) begin
                                    state_q <= StWaitEnd;
                                end
                            end
                            StEthHdr: begin
                                cnt_q <= cnt_q + 16'd1;
                                if (cnt_q == 16'd0) begin
                                    mac_match_q <= (gmii_rxd == mac_byte);
                                    bcast_q     <= (gmii_rxd == 8'hFF);
                                end else if (cnt_q <= 16'd5) begin
                                    mac_match_q <= mac_match_q && (gmii_rxd == mac_byte);
                                    bcast_q     <= bcast_q && (gmii_rxd == 8'hFF);
                                end
                                if (cnt_q == 16'd12) hi_byte_q <= gmii_rxd;
                                if (cnt_q == 16'd13) begin
                                    cnt_q <= 16'd0;
                                    if ((mac_match_q || bcast_q) &&
                                        {hi_byte_q, gmii_rxd} == 16'h0800) begin
                                        state_q <= StIpHdr;
                                    end else begin
                                        state_q  <= StWaitEnd;
                                        pkt_drop <= 1'b1;
                                    end
                                end
                            end
                            StIpHdr: begin
                                cnt_q <= cnt_q + 16'd1;
                                if (cnt_q == 16'd0) hdr_ok_q <= (gmii_rxd == 8'h45);
                                if (cnt_q == 16'd9) hdr_ok_q <= hdr_ok_q && (gmii_rxd == 8'h11);
                                if (cnt_q == 16'd19) begin
                                    cnt_q <= 16'd0;
                                    if (hdr_ok_q) begin
                                        state_q <= StUdpHdr;
                                    end else begin
                                        state_q  <= StWaitEnd;
                                        pkt_drop <= 1'b1;
                                    end
                                end
                            end
                            StUdpHdr: begin
                                cnt_q <= cnt_q + 16'd1;
                                if (cnt_q == 16'd2 || cnt_q == 16'd4) hi_byte_q <= gmii_rxd;
                                if (cnt_q == 16'd3) hdr_ok_q <= ({hi_byte_q, gmii_rxd} == LOCAL_PORT);
                                if (cnt_q == 16'd5) ulen_q <= {hi_byte_q, gmii_rxd};
                                if (cnt_q == 16'd7) begin
                                    cnt_q     <= 16'd0;
                                    pay_len_q <= pay_calc;
                                    if (hdr_ok_q && len_ok) begin
                                        if (pay_calc == 16'd0) begin
                                            state_q  <= StWaitEnd;
                                            pkt_done <= 1'b1;
                                        end else begin
                                            state_q <= StPayload;
                                        end
                                    end else begin
                                        state_q  <= StWaitEnd;
                                        pkt_drop <= 1'b1;
                                    end
                                end
                            end
                            StPayload: begin
                                cnt_q <= cnt_q + 16'd1;
                                if (cnt_q == 16'd0) pkt_start <= 1'b1;
                                case (cnt_q[1:0])
                                    2'd0: b0_q <= gmii_rxd;
                                    2'd1: b1_q <= gmii_rxd;
                                    2'd2: b2_q <= gmii_rxd;
                                    default: begin
                                        ldata_out    <= {b0_q, b1_q};
                                        rdata_out    <= {b2_q, gmii_rxd};
                                        sample_valid <= 1'b1;
                                    end
                                endcase
                                if (cnt_q == pay_len_q - 16'd1) begin
                                    state_q  <= StWaitEnd;
                                    pkt_done <= 1'b1;
                                end
                            end
                            default: state_q <= StWaitEnd;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef UDP_AUDIO_RX_STAT_EN
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            good_pkt_cnt <= 16'd0;
            drop_pkt_cnt <= 16'd0;
        end else begin
            if (pkt_done) good_pkt_cnt <= good_pkt_cnt + 16'd1;
            if (pkt_drop) drop_pkt_cnt <= drop_pkt_cnt + 16'd1;
        end
    end
`endif

endmodule
